// File: rtl/main_memory_responder.sv
// Memory-side responder: accepts one strobed read/write, waits a fixed number
// of states, commits to the internal word store and pulses MReady.
module main_memory_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
  output logic              MBusy
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
      $error("main_memory_responder: WAIT_CYCLES must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;
  logic [7:0]        cnt_next;
  logic              capture;
  logic              wr_commit;
  logic              rd_commit;
  logic              clr_out;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      MDataOut <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        rw_q   <= MRW;
        addr_q <= MAddr;
        data_q <= MDataIn;
      end
      if (rd_commit) begin
        MDataOut <= mem[addr_q];
      end else if (clr_out) begin
        MDataOut <= '0;
      end
    end
  end

  // Store is never cleared; a write caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_commit && !reset) begin
      mem[addr_q] <= data_q;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    wr_commit  = 1'b0;
    rd_commit  = 1'b0;
    clr_out    = 1'b0;
    case (state)
      IDLE: begin
        if (MStrobe) begin
          capture    = 1'b1;
          cnt_next   = 8'(WAIT_CYCLES - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 8'd0) begin
          cnt_next = cnt - 8'd1;
        end else begin
          state_next = DONE;
          if (rw_q) wr_commit = 1'b1;
          else      rd_commit = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
        clr_out    = 1'b1;
      end
    endcase
  end

  assign MReady = (state == DONE);
  assign MBusy  = (state == BUSY) || (state == DONE);

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: a WAIT_CYCLES=4 instance and a
// WAIT_CYCLES=1 instance share clock and reset.
module tb_main_memory_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       strobe0, rw0, strobe1, rw1;
  logic [7:0] addr0, din0, addr1, din1;
  logic [7:0] dout0, dout1;
  logic       ready0, busy0, ready1, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  main_memory_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .MStrobe(strobe0), .MRW(rw0), .MAddr(addr0),
    .MDataIn(din0), .MDataOut(dout0), .MReady(ready0), .MBusy(busy0)
  );

  main_memory_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .MStrobe(strobe1), .MRW(rw1), .MAddr(addr1),
    .MDataIn(din1), .MDataOut(dout1), .MReady(ready1), .MBusy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One access; j counts negedges after the strobe edge (j=0 first BUSY cycle).
  // junk drives garbage on the inputs (strobe included) while the access runs.
  task automatic access(input bit sel, input logic rw, input logic [7:0] a,
                        input logic [7:0] d, input bit junk,
                        output logic [7:0] rd, output int rdy_at,
                        output int busy_n, output int rdy_n);
    logic b, r;
    @(negedge clk);
    if (sel) begin strobe1 = 1'b1; rw1 = rw; addr1 = a; din1 = d; end
    else     begin strobe0 = 1'b1; rw0 = rw; addr0 = a; din0 = d; end
    @(posedge clk);
    #1;
    if (junk) begin addr0 = 8'h21; din0 = 8'hFF; rw0 = 1'b1; end
    else begin strobe0 = 1'b0; strobe1 = 1'b0; end
    rdy_at = -1; busy_n = 0; rdy_n = 0; rd = '0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      b = sel ? busy1 : busy0;
      r = sel ? ready1 : ready0;
      if (b) busy_n++;
      if (r) begin
        rdy_n++;
        if (rdy_at < 0) begin
          rdy_at = j;
          rd = sel ? dout1 : dout0;
        end
        strobe0 = 1'b0;
      end
      if (!b) break;
    end
  endtask

  logic [7:0] rd;
  int rdy_at, busy_n, rdy_n;
  int pulses[$];
  int idle_gap;

  initial begin
    reset = 1'b1;
    strobe0 = 0; rw0 = 0; addr0 = 0; din0 = 0;
    strobe1 = 0; rw1 = 0; addr1 = 0; din1 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_dout", 32'(dout0), 32'h00);

    // Test 1: write 0x10=0xA5
    access(1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, rd, rdy_at, busy_n, rdy_n);
    chk("wr_ready_at", 32'(rdy_at), 32'd4);
    chk("wr_busy_cycles", 32'(busy_n), 32'd5);
    chk("wr_ready_pulses", 32'(rdy_n), 32'd1);
    chk("wr_dout_unchanged", 32'(dout0), 32'h00);

    // Test 2: read back 0x10
    access(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, rd, rdy_at, busy_n, rdy_n);
    chk("rd_ready_at", 32'(rdy_at), 32'd4);
    chk("rd_data", 32'(rd), 32'hA5);
    repeat (2) @(negedge clk);
    chk("rd_data_held", 32'(dout0), 32'hA5);

    // Test 3: inputs changed mid-access
    access(1'b0, 1'b1, 8'h21, 8'h5A, 1'b0, rd, rdy_at, busy_n, rdy_n);
    access(1'b0, 1'b1, 8'h20, 8'h3C, 1'b1, rd, rdy_at, busy_n, rdy_n);
    chk("mid_ready_pulses", 32'(rdy_n), 32'd1);
    chk("mid_busy_cycles", 32'(busy_n), 32'd5);
    access(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, rd, rdy_at, busy_n, rdy_n);
    chk("mid_store_20", 32'(rd), 32'h3C);
    access(1'b0, 1'b0, 8'h21, 8'h00, 1'b0, rd, rdy_at, busy_n, rdy_n);
    chk("mid_store_21", 32'(rd), 32'h5A);

    // Test 4: strobe held high, reads of 0x10
    @(negedge clk);
    strobe0 = 1'b1; rw0 = 1'b0; addr0 = 8'h10;
    idle_gap = -1;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (ready0) pulses.push_back(j);
      if (!busy0 && idle_gap < 0) idle_gap = j;
    end
    strobe0 = 1'b0;
    chk("cont_pulse_count", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("cont_first", 32'(pulses[0]), 32'd4);
      chk("cont_gap1", 32'(pulses[1] - pulses[0]), 32'd6);
      chk("cont_gap2", 32'(pulses[2] - pulses[1]), 32'd6);
    end
    chk("cont_idle_slot", 32'(idle_gap), 32'd5);
    chk("cont_data", 32'(dout0), 32'hA5);
    repeat (8) @(negedge clk);

    // Test 5: reset aborts a write in BUSY
    access(1'b0, 1'b1, 8'h30, 8'h11, 1'b0, rd, rdy_at, busy_n, rdy_n);
    @(negedge clk);
    strobe0 = 1'b1; rw0 = 1'b1; addr0 = 8'h30; din0 = 8'h77;
    @(posedge clk);
    #1 strobe0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", 32'(busy0), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready0), 32'd0);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_dout", 32'(dout0), 32'h00);
    rdy_n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready0) rdy_n++;
    end
    chk("abort_no_ready", 32'(rdy_n), 32'd0);
    access(1'b0, 1'b0, 8'h30, 8'h00, 1'b0, rd, rdy_at, busy_n, rdy_n);
    chk("abort_store_kept", 32'(rd), 32'h11);

    // Test 6: WAIT_CYCLES=1 instance
    access(1'b1, 1'b1, 8'h05, 8'hC3, 1'b0, rd, rdy_at, busy_n, rdy_n);
    chk("w1_wr_ready_at", 32'(rdy_at), 32'd1);
    access(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, rd, rdy_at, busy_n, rdy_n);
    chk("w1_rd_ready_at", 32'(rdy_at), 32'd1);
    chk("w1_rd_busy_cycles", 32'(busy_n), 32'd2);
    chk("w1_rd_data", 32'(rd), 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
